ifetch_unit: RTL

- Multicycle instruction-fetch stage sitting directly upstream of the single-cycle control decoder.
- Holds the PC and fetches one instruction at a time from instruction memory over a req/ack handshake.
- Presents Instruction/OpCode/Funct to decode with a valid/ready handshake.
- Computes the next PC from the control outputs (PCSrc, Branch) and the ALU Zero once downstream signals that the instruction has resolved.
- Non-speculative: the next fetch starts only after resolution.

---
 rtl/ifetch_unit_if.sv | 51 +++++
 rtl/ifetch_unit.sv | 131 +++++++++++++
 2 files changed

// File: rtl/ifetch_unit_if.sv
// ifetch_unit_if
//   Groups the instruction-memory bus, the decode handshake and the
//   next-PC resolution inputs of the fetch stage into one bundle.
//
//   Handshake semantics:
//     - imem_req/imem_ack: the fetch unit holds imem_req=1 with a stable
//       imem_addr until memory returns a single-cycle imem_ack. imem_rdata
//       is valid only in the ack cycle.
//     - inst_valid/inst_ready: the instruction is transferred in the cycle
//       where both are high. inst_valid does not drop before that transfer,
//       and the Instruction/PC outputs stay stable while it is high.
//     - resolve_valid: PCSrc/Branch/Zero/JrTarget are sampled only in a
//       cycle with resolve_valid=1, once the instruction has been accepted.
//
//   Modports:
//     master - the fetch unit (drives imem_req, decode outputs, counter)
//     slave  - memory/decode/execute environment (drives acks and resolves)

interface ifetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] Instruction;
    logic [5:0]  OpCode;
    logic [5:0]  Funct;
    logic [31:0] PC;
    logic [31:0] PC_plus4;
    logic        resolve_valid;
    logic [1:0]  PCSrc;
    logic        Branch;
    logic        Zero;
    logic [31:0] JrTarget;
    logic [31:0] retired_count;

    modport master (
        output imem_req, imem_addr, inst_valid, Instruction, OpCode, Funct,
               PC, PC_plus4, retired_count,
        input  imem_ack, imem_rdata, inst_ready, resolve_valid, PCSrc,
               Branch, Zero, JrTarget
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, Instruction, OpCode, Funct,
               PC, PC_plus4, retired_count,
        output imem_ack, imem_rdata, inst_ready, resolve_valid, PCSrc,
               Branch, Zero, JrTarget
    );
endinterface

// File: rtl/ifetch_unit.sv
// ifetch_unit
//   Non-speculative multicycle instruction fetch stage. Fetches one word at
//   the PC, presents it to decode, then waits for the instruction to resolve
//   before computing the next PC and starting the next fetch.
//
//   Ports:
//     clk         - system clock, rising edge
//     reset       - asynchronous, active-high reset
//     bus         - ifetch_unit_if.master (memory, decode and resolve signals)
//     o_dbg_state - current FSM state (0 FETCH, 1 ISSUE, 2 RESOLVE)

module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    ifetch_unit_if.master bus,
    output logic [1:0]    o_dbg_state
);

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RESOLVE = 2'd2
    } state_t;

    // Word alignment is enforced everywhere the PC is loaded.
    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_retired;

    logic        w_load_instr;
    logic        w_resolve;
    logic        w_imem_req;
    logic        w_inst_valid;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_off;
    logic [31:0] w_jr_target;
    logic [31:0] w_next_pc;

    assign w_pc_plus4  = r_pc + 32'd4;
    assign w_br_off    = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
    assign w_jr_target = bus.JrTarget & 32'hFFFF_FFFC;

    // Next-PC select; PCSrc 10/11 fall through to the sequential/branch path.
    always_comb begin
        w_next_pc = w_pc_plus4;
        if (bus.PCSrc == 2'b01) begin
            if (r_instr[31:26] == 6'd0) begin
                w_next_pc = w_jr_target;
            end else begin
                w_next_pc = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
            end
        end else if (bus.Branch && bus.Zero) begin
            w_next_pc = w_pc_plus4 + w_br_off;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load_instr = 1'b0;
        w_resolve    = 1'b0;
        w_imem_req   = 1'b0;
        w_inst_valid = 1'b0;
        case (r_state)
            ST_FETCH: begin
                w_imem_req = 1'b1;
                if (bus.imem_ack) begin
                    w_load_instr = 1'b1;
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_inst_valid = 1'b1;
                if (bus.inst_ready) begin
                    if (bus.resolve_valid) begin
                        w_resolve    = 1'b1;
                        w_state_next = ST_FETCH;
                    end else begin
                        w_state_next = ST_RESOLVE;
                    end
                end
            end
            ST_RESOLVE: begin
                if (bus.resolve_valid) begin
                    w_resolve    = 1'b1;
                    w_state_next = ST_FETCH;
                end
            end
            default: begin
                w_state_next = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_FETCH;
            r_pc      <= RESET_PC_ALIGNED;
            r_instr   <= 32'd0;
            r_retired <= 32'd0;
        end else begin
            r_state <= w_state_next;
            if (w_load_instr) begin
                r_instr <= bus.imem_rdata;
            end
            if (w_resolve) begin
                r_pc      <= w_next_pc;
                r_retired <= r_retired + 32'd1;
            end
        end
    end

    // The reset state is FETCH, so the request is masked while reset is held
    // to keep memory from seeing a request it would drop anyway.
    assign bus.imem_req      = w_imem_req & ~reset;
    assign bus.inst_valid    = w_inst_valid & ~reset;
    assign bus.imem_addr     = r_pc;
    assign bus.Instruction   = r_instr;
    assign bus.OpCode        = r_instr[31:26];
    assign bus.Funct         = r_instr[5:0];
    assign bus.PC            = r_pc;
    assign bus.PC_plus4      = w_pc_plus4;
    assign bus.retired_count = r_retired;
    assign o_dbg_state       = r_state;

endmodule
